// File: rtl/perf_mon_pkg.sv
// perf_mon_pkg
//   Shared definitions for the pipeline performance monitor: the FSM state
//   encoding, its width, and the upper bound on the number of event channels.
//   Imported by pipeline_perf_monitor and perf_event_counter.
package perf_mon_pkg;

   localparam int STATE_W     = 2;
   localparam int MAX_NUM_EVT = 15;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

endpackage

// File: rtl/perf_event_counter.sv
// perf_event_counter
//   One CNT_W-bit performance counter with a sticky overflow flag.
//   Build option: PERF_MON_SATURATE_EN
//     defined   - the counter holds at all-ones; a dropped increment sets ovf_o.
//     undefined - the counter wraps modulo 2^CNT_W; the wrap edge sets ovf_o.
// Ports:
//   clk_i  - clock, rising edge
//   rst_i  - asynchronous active-low reset
//   inc_i  - count one on this edge
//   clr_i  - synchronous clear of count and overflow (wins over inc_i)
//   frz_i  - hold the count regardless of inc_i
//   cnt_o  - current count
//   ovf_o  - sticky overflow flag
module perf_event_counter
   import perf_mon_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic             frz_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             at_max;

   assign at_max = &cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr_i) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (inc_i && !frz_i) begin
`ifdef PERF_MON_SATURATE_EN
         if (at_max) ovf_d = 1'b1;
         else        cnt_d = cnt_q + 1'b1;
`else
         cnt_d = cnt_q + 1'b1;
         if (at_max) ovf_d = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;

endmodule

// File: rtl/pipeline_perf_monitor.sv
// pipeline_perf_monitor
//   Performance monitor for the pipelined CPU: a free-running cycle counter
//   (channel 0) plus NUM_EVT event counters (channels 1..NUM_EVT), an
//   IDLE/RUN/HALT control FSM with an optional cycle-limit halt, a shadow bank
//   loaded under a four-phase snapshot handshake, and a registered read port.
//   Build option: PERF_MON_SATURATE_EN (saturate instead of wrap; handled
//   inside perf_event_counter).
// Ports:
//   clk_i, rst_i   - clock / asynchronous active-low reset
//   start_i        - count enable level (shared with the CPU start)
//   clear_i        - clears live counters and overflow flags, returns to IDLE
//   limit_i        - cycle limit, 0 = unlimited
//   evt_i          - event strobes, bit k feeds channel k+1
//   snap_req_i     - snapshot request; snap_ack_o - acknowledge
//   rd_sel_i       - shadow read index; rd_data_o - registered shadow value
//   ovf_o          - sticky overflow flags, bit 0 = cycle counter
//   state_o        - FSM state; done_o - high while halted
module pipeline_perf_monitor
   import perf_mon_pkg::*;
#(
   parameter  int NUM_EVT = 4,
   parameter  int CNT_W   = 32,
   localparam int SEL_W   = $clog2(NUM_EVT + 1)
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               clear_i,
   input  logic [CNT_W-1:0]   limit_i,
   input  logic [NUM_EVT-1:0] evt_i,
   input  logic               snap_req_i,
   output logic               snap_ack_o,
   input  logic [SEL_W-1:0]   rd_sel_i,
   output logic [CNT_W-1:0]   rd_data_o,
   output logic [NUM_EVT:0]   ovf_o,
   output logic [1:0]         state_o,
   output logic               done_o
);

   localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_EVT);

   state_e             state_q, state_d;
   logic               done_q, done_d;
   logic               snap_ack_q, snap_ack_d;
   logic [CNT_W-1:0]   rd_data_q, rd_data_d;
   logic [CNT_W-1:0]   shadow_q [NUM_EVT+1];
   logic [CNT_W-1:0]   shadow_d [NUM_EVT+1];

   logic [CNT_W-1:0]   cnt_w [NUM_EVT+1];
   logic [NUM_EVT:0]   inc_w;
   logic [NUM_EVT:0]   ovf_w;
   logic               cnt_en;
   logic               frz_w;
   logic               capture_w;
   logic [CNT_W-1:0]   cyc_next;
   logic               limit_hit;

   // Counting happens only on RUN edges that still see start_i; the edge that
   // leaves RUN because start_i dropped does not count.
   assign cnt_en = (state_q == ST_RUN) && start_i;
   assign frz_w  = (state_q == ST_HALT);
   assign inc_w  = {evt_i, 1'b1} & {(NUM_EVT + 1){cnt_en}};

   for (genvar gi = 0; gi <= NUM_EVT; gi++) begin : g_cnt
      perf_event_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .inc_i (inc_w[gi]),
         .clr_i (clear_i),
         .frz_i (frz_w),
         .cnt_o (cnt_w[gi]),
         .ovf_o (ovf_w[gi])
      );
   end

   // Halt on the edge where the cycle count reaches the limit. A saturated
   // counter yields cyc_next = 0, which never matches a nonzero limit.
   assign cyc_next  = cnt_w[0] + 1'b1;
   assign limit_hit = (limit_i != '0) && (cyc_next == limit_i);

   // A capture needs the acknowledge low, so one request loads the bank once.
   assign capture_w = snap_req_i && !snap_ack_q;

   always_comb begin
      state_d = state_q;
      if (clear_i) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: if (start_i) state_d = ST_RUN;
            ST_RUN: begin
               if (!start_i)       state_d = ST_IDLE;
               else if (limit_hit) state_d = ST_HALT;
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
         endcase
      end
      done_d     = (state_d == ST_HALT);
      snap_ack_d = snap_req_i;
      for (int i = 0; i <= NUM_EVT; i++) begin
         shadow_d[i] = capture_w ? cnt_w[i] : shadow_q[i];
      end
      rd_data_d = (rd_sel_i <= MAX_SEL) ? shadow_q[rd_sel_i] : '0;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q    <= ST_IDLE;
         done_q     <= 1'b0;
         snap_ack_q <= 1'b0;
         rd_data_q  <= '0;
         for (int i = 0; i <= NUM_EVT; i++) shadow_q[i] <= '0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         snap_ack_q <= snap_ack_d;
         rd_data_q  <= rd_data_d;
         for (int i = 0; i <= NUM_EVT; i++) shadow_q[i] <= shadow_d[i];
      end
   end

   assign snap_ack_o = snap_ack_q;
   assign rd_data_o  = rd_data_q;
   assign ovf_o      = ovf_w;
   assign state_o    = state_q;
   assign done_o     = done_q;

endmodule
